counter_arbiter: RTL and testbench
==================================

# counter_arbiter

Round-robin scheduler that shares a single synchronous N-bit interval counter among R requesters. Each requester asks for the counter with a duration; the block grants one requester at a time, runs the counter from 0 up to the latched duration, then pulses that requester's done. It sits between timing clients and the counter resource so that only one interval runs at any moment.

## Interface
- `N`, default 4: counter and duration width, ≥1.
- `R`, default 4: number of requesters, ≥2.

- `clk`, input, 1: rising-edge clock; the only clock in the block.
- `reset`, input, 1: synchronous, active-high reset.
- `req`, input, R: request per requester. A requester holds it high until its done, or drops it early to abort.
- `dur`, input, R*N: packed durations. Requester i uses `dur[i*N +: N]`. Sampled only in the cycle its grant is decided.
- `gnt`, output, R: one-hot grant. Held high for the whole counting interval.
- `done`, output, R: one-hot, single-cycle pulse at the end of a completed interval.
- `busy`, output, 1: high while any grant is active.
- `count`, output, N: current counter value. 0 when idle.

## Operation
- **States:** IDLE and COUNT.
- **Registered signals:** `gnt`, `done`, `count`, `busy`, state, the latched duration `D`, the winner index `w`, and the round-robin pointer `ptr`.
- **IDLE:**
  - The eligible set is `req` with the bit masked whose `done` is high in this cycle.
  - If the set is empty, stay in IDLE.
  - Otherwise the winner is the first eligible index found searching upward from `ptr`, modulo R.
  - At the next edge: `gnt[w]`=1, `busy`=1, `count`=0, `D`=dur of w, `ptr`=(w+1) mod R, go to COUNT.
- **COUNT, completion:** if `req[w]`=1 and `count`==D, then at the next edge: `gnt`=0, `busy`=0, `count`=0, `done[w]`=1 for exactly one cycle, go to IDLE.
- **COUNT, normal step:** if `req[w]`=1 and `count`<D, then `count` increments by 1.
- **COUNT, abort:** if `req[w]`=0, then at the next edge: `gnt`=0, `busy`=0, `count`=0, no done, go to IDLE. `ptr` has already advanced past w.
- **Counter range:** the counter never wraps, because it stops at D ≤ 2^N−1. Arithmetic is unsigned N-bit.
- **Ignored inputs:**
  - Changes to `dur` while in COUNT.
  - `req` of non-granted requesters while in COUNT. They wait; there is no preemption.
- **Back-to-back jobs:** the done cycle is itself an IDLE arbitration cycle. The masking rule stops a requester that still holds req during its own done cycle from being immediately re-granted. A sole requester still holding req in the cycle after done is granted again.

## Timing
- **Reset:** when `reset`=1 at an edge, the next cycle has `gnt`=0, `done`=0, `busy`=0, `count`=0, state IDLE, `ptr`=0, `D`=0. Reset takes priority over every other event.
- **Reset mid-interval:** the interval is discarded and no done is issued.
- **Request to grant:** with `req` sampled high in IDLE at cycle T, `gnt` is high from T+1.
- **Completed interval:**
  - Grant lasts D+1 cycles, T+1 … T+1+D, with `count` = 0 … D.
  - `done` is high at T+2+D.
  - The next grant can start at T+3+D.
  - Job-to-job period for continuous load: D+2 cycles.
- **Abort:** if `req[w]` is low at cycle t during COUNT, `gnt` is low from t+1. The earliest new grant is at t+2.
- **Fairness:** with all R requesters permanently requesting, grants rotate 0,1,…,R−1,0 starting from `ptr`.
- **Signal relationships:**
  - `done` and `gnt` are never high in the same cycle.
  - At most one `gnt` bit and at most one `done` bit are high at any time.

## Test plan
1. **Single completed job:** reset, then `req`=0001 with dur0=3, held until done → `gnt`=0001 for 4 cycles with `count` 0,1,2,3; `done`=0001 in the next cycle; `busy` high exactly 4 cycles; then all outputs 0.
2. **Zero duration:** `req`=0100 with dur2=0 → `gnt`=0100 for 1 cycle with `count`=0; `done`=0100 in the following cycle.
3. **Round-robin rotation:** from reset, `req`=1111 held permanently, all dur=1 → grant order 0,1,2,3,0,1. Each grant lasts 2 cycles; a 1-cycle done sits between consecutive grants; no requester is granted twice in a row.
4. **Abort:**
   - Stimulus: `req`=0011, dur0=9, dur1=2. Requester 0 wins; drop `req[0]` in the cycle where `count`=4.
   - Required response: `gnt`=0 next cycle with no done[0]. `gnt`=0010 the cycle after that; `done`=0010 after 3 grant cycles.
5. **Reset mid-interval:** dur0=12; assert `reset` for 1 cycle when `count`=5 → next cycle all outputs 0 and no done ever appears. With `req`=1000 afterwards, the first grant goes to requester 3 after a search starting from `ptr`=0.
6. **Maximum duration and dur change during COUNT:** dur1=15 (N=4), and change dur1 to 2 during COUNT → grant lasts 16 cycles; `count` reaches 15 with no wrap; done[1] follows.

Source files
------------

// File: rtl/counter_arbiter_if.sv
// Bundle of request/grant/counter signals shared between timing clients
// (master side) and the counter_arbiter scheduler (slave side).
interface counter_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned R = 4
);
    logic [R-1:0]   req;
    logic [R*N-1:0] dur;
    logic [R-1:0]   gnt;
    logic [R-1:0]   done;
    logic           busy;
    logic [N-1:0]   count;

    modport master (
        output req, dur,
        input  gnt, done, busy, count
    );

    modport slave (
        input  req, dur,
        output gnt, done, busy, count
    );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin scheduler sharing one N-bit interval counter among R
// requesters: grants one requester, counts 0..D, then pulses its done.
module counter_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned R = 4
) (
    input  logic              clk,
    input  logic              reset,
    counter_arbiter_if.slave  bus
);
    localparam int unsigned W = (R > 1) ? $clog2(R) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] COUNT = 1'b1;

    logic [0:0]   state;
    logic [N-1:0] d_q;
    logic [W-1:0] w_q;
    logic [W-1:0] ptr;
    logic [R-1:0] gnt_q;
    logic [R-1:0] done_q;
    logic         busy_q;
    logic [N-1:0] count_q;

    logic [R-1:0] eligible;
    logic         found;
    logic [W-1:0] idx;
    logic [W-1:0] win;
    logic [W-1:0] ptr_next;
    logic [N-1:0] win_dur;
    logic [R-1:0] win_onehot;

    // Winner search: first eligible index upward from ptr, wrapping modulo R.
    // A requester pulsing done this cycle is masked so it cannot be re-granted
    // straight out of its own completion.
    always_comb begin
        eligible = bus.req & ~done_q;
        found    = 1'b0;
        win      = '0;
        idx      = '0;
        for (int unsigned k = 0; k < R; k++) begin
            idx = W'((32'(ptr) + k) % R);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Duration, one-hot grant and next pointer for the selected winner.
    always_comb begin
        win_dur = '0;
        for (int unsigned i = 0; i < R; i++) begin
            if (W'(i) == win) begin
                win_dur = bus.dur[i*N +: N];
            end
        end
        win_onehot      = '0;
        win_onehot[win] = 1'b1;
        ptr_next        = (32'(win) + 1 == R) ? '0 : win + 1'b1;
    end

    // Arbitration and interval counting state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            d_q     <= '0;
            w_q     <= '0;
            ptr     <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= COUNT;
                        gnt_q   <= win_onehot;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                        d_q     <= win_dur;
                        w_q     <= win;
                        ptr     <= ptr_next;
                    end
                end
                COUNT: begin
                    if (!bus.req[w_q]) begin
                        state   <= IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                    end else if (count_q == d_q) begin
                        state       <= IDLE;
                        gnt_q       <= '0;
                        busy_q      <= 1'b0;
                        count_q     <= '0;
                        done_q[w_q] <= 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;
endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter: directed scenarios plus a
// randomized run, all compared against a job-level reference model.
module tb_counter_arbiter;
    localparam int N = 4;
    localparam int R = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    counter_arbiter_if #(.N(N), .R(R)) bus ();

    counter_arbiter #(.N(N), .R(R)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] dut_o;
    assign dut_o = {bus.gnt, bus.done, bus.busy, bus.count};

    // Reference model: one running job (owner, length, elapsed) plus a pointer.
    bit       m_active  = 1'b0;
    int       m_owner   = 0;
    int       m_D       = 0;
    int       m_elapsed = 0;
    int       m_ptr     = 0;
    bit [3:0] m_done    = '0;
    int       m_pick;
    int       m_pick_dur;
    logic [12:0] exp_o;

    function automatic int pick(input logic [3:0] elig, input int p);
        for (int k = 0; k < R; k++) begin
            if (elig[(p + k) % R]) return (p + k) % R;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < R; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Candidate for the next job, from the request set minus finishing requester.
    always_comb begin
        m_pick     = pick(bus.req & ~m_done, m_ptr);
        m_pick_dur = 0;
        if (m_pick >= 0) m_pick_dur = int'(bus.dur[m_pick*N +: N]);
    end

    // Expected outputs derived from the model's job state.
    always_comb begin
        if (m_active) exp_o = {4'b0001 << m_owner, m_done, 1'b1, 4'(m_elapsed)};
        else          exp_o = {4'b0000, m_done, 1'b0, 4'b0000};
    end

    // Model advance: start, count, finish or abandon a job each clock.
    always @(posedge clk) begin
        if (reset) begin
            m_active  <= 1'b0;
            m_done    <= '0;
            m_elapsed <= 0;
            m_ptr     <= 0;
            m_D       <= 0;
        end else if (m_active) begin
            if (!bus.req[m_owner]) begin
                m_active <= 1'b0;
                m_done   <= '0;
            end else if (m_elapsed == m_D) begin
                m_active <= 1'b0;
                m_done   <= 4'b0001 << m_owner;
            end else begin
                m_elapsed <= m_elapsed + 1;
                m_done    <= '0;
            end
        end else begin
            m_done <= '0;
            if (m_pick >= 0) begin
                m_active  <= 1'b1;
                m_owner   <= m_pick;
                m_D       <= m_pick_dur;
                m_elapsed <= 0;
                m_ptr     <= (m_pick + 1) % R;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dur(input int i, input int v);
        logic [31:0] tmp;
        tmp = 32'(v);
        bus.dur[i*N +: N] = tmp[N-1:0];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.dur = '0;
        tick();
        tick();
        n_checks++;
        if (dut_o !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", dut_o, 13'h0);
        end
        n_checks++;
        if (dut_o !== exp_o) begin
            n_fail++;
            $display("FAIL reset_model: got %h want %h", dut_o, exp_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_job();
        logic [12:0] want;
        do_reset();
        set_dur(0, 3);
        bus.req = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 4)      want = {4'b0001, 4'b0000, 1'b1, 4'(c - 1)};
            else if (c == 5) want = {4'b0000, 4'b0001, 1'b0, 4'b0000};
            else             want = '0;
            n_checks++;
            if (dut_o !== want) begin
                n_fail++;
                $display("FAIL single_job c%0d: got %h want %h", c, dut_o, want);
            end
            n_checks++;
            if (dut_o !== exp_o) begin
                n_fail++;
                $display("FAIL single_job_model c%0d: got %h want %h", c, dut_o, exp_o);
            end
            if (c == 5) bus.req = '0;
        end
    endtask

    task automatic test_zero_dur();
        logic [12:0] want;
        set_dur(2, 0);
        bus.req = 4'b0100;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1)      want = {4'b0100, 4'b0000, 1'b1, 4'b0000};
            else if (c == 2) want = {4'b0000, 4'b0100, 1'b0, 4'b0000};
            else             want = '0;
            n_checks++;
            if (dut_o !== want) begin
                n_fail++;
                $display("FAIL zero_dur c%0d: got %h want %h", c, dut_o, want);
            end
            if (c == 2) bus.req = '0;
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int run_len;
        logic [3:0] prev_gnt;
        do_reset();
        bus.dur = 16'h1111;
        bus.req = 4'b1111;
        prev_gnt = '0;
        run_len  = 0;
        for (int c = 1; c <= 18; c++) begin
            tick();
            n_checks++;
            if (dut_o !== exp_o) begin
                n_fail++;
                $display("FAIL rr_model c%0d: got %h want %h", c, dut_o, exp_o);
            end
            n_checks++;
            if ((|bus.gnt) && (|bus.done)) begin
                n_fail++;
                $display("FAIL rr_gnt_done_overlap c%0d: gnt %b done %b, want no overlap", c, bus.gnt, bus.done);
            end
            if (bus.gnt != 4'b0000 && prev_gnt == 4'b0000) order.push_back(onehot_idx(bus.gnt));
            if (bus.gnt != 4'b0000) run_len++;
            if (bus.gnt == 4'b0000 && prev_gnt != 4'b0000) begin
                n_checks++;
                if (run_len != 2) begin
                    n_fail++;
                    $display("FAIL rr_grant_len: got %0d want 2", run_len);
                end
                run_len = 0;
            end
            prev_gnt = bus.gnt;
        end
        bus.req = '0;
        n_checks++;
        if (order.size() != 6) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d want 6", order.size());
        end else begin
            for (int g = 0; g < 6; g++) begin
                n_checks++;
                if (order[g] != g % R) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", g, order[g], g % R);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [12:0] wants[5];
        bit hit;
        do_reset();
        bus.dur = {4'd0, 4'd0, 4'd2, 4'd9};
        bus.req = 4'b0011;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            tick();
            n_checks++;
            if (dut_o !== exp_o) begin
                n_fail++;
                $display("FAIL abort_model c%0d: got %h want %h", c, dut_o, exp_o);
            end
            if (bus.gnt === 4'b0001 && bus.count === 4'd4) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL abort_wait: got no count=4 on requester 0 within 20 cycles, want it");
            bus.req = '0;
            return;
        end
        bus.req = 4'b0010;
        wants[0] = '0;
        wants[1] = {4'b0010, 4'b0000, 1'b1, 4'd0};
        wants[2] = {4'b0010, 4'b0000, 1'b1, 4'd1};
        wants[3] = {4'b0010, 4'b0000, 1'b1, 4'd2};
        wants[4] = {4'b0000, 4'b0010, 1'b0, 4'd0};
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (dut_o !== wants[c]) begin
                n_fail++;
                $display("FAIL abort_seq c%0d: got %h want %h", c, dut_o, wants[c]);
            end
        end
        bus.req = '0;
    endtask

    task automatic test_reset_mid();
        logic [12:0] wants[5];
        bit hit;
        do_reset();
        bus.dur = 16'h200C;
        bus.req = 4'b0001;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            tick();
            if (bus.gnt === 4'b0001 && bus.count === 4'd5) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got no count=5 within 20 cycles, want it");
            bus.req = '0;
            return;
        end
        reset = 1'b1;
        bus.req = 4'b1000;
        wants[0] = '0;
        wants[1] = {4'b1000, 4'b0000, 1'b1, 4'd0};
        wants[2] = {4'b1000, 4'b0000, 1'b1, 4'd1};
        wants[3] = {4'b1000, 4'b0000, 1'b1, 4'd2};
        wants[4] = {4'b0000, 4'b1000, 1'b0, 4'd0};
        for (int c = 0; c < 5; c++) begin
            tick();
            reset = 1'b0;
            n_checks++;
            if (dut_o !== wants[c]) begin
                n_fail++;
                $display("FAIL reset_mid_seq c%0d: got %h want %h", c, dut_o, wants[c]);
            end
        end
        bus.req = '0;
    endtask

    task automatic test_max_dur();
        logic [12:0] want;
        do_reset();
        set_dur(1, 15);
        bus.req = 4'b0010;
        for (int c = 0; c <= 17; c++) begin
            tick();
            if (c <= 15)      want = {4'b0010, 4'b0000, 1'b1, 4'(c)};
            else if (c == 16) want = {4'b0000, 4'b0010, 1'b0, 4'b0000};
            else              want = '0;
            n_checks++;
            if (dut_o !== want) begin
                n_fail++;
                $display("FAIL max_dur c%0d: got %h want %h", c, dut_o, want);
            end
            if (c == 0)  set_dur(1, 2);
            if (c == 16) bus.req = '0;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            n_checks++;
            if (dut_o !== exp_o) begin
                n_fail++;
                $display("FAIL random_model c%0d: got %h want %h", c, dut_o, exp_o);
            end
            n_checks++;
            if ($countones(bus.gnt) > 1 || $countones(bus.done) > 1 || ((|bus.gnt) && (|bus.done))) begin
                n_fail++;
                $display("FAIL random_onehot c%0d: gnt %b done %b, want one-hot and disjoint", c, bus.gnt, bus.done);
            end
            reset = ($urandom_range(299) == 0);
            for (int i = 0; i < R; i++) begin
                if (bus.req[i]) begin
                    if (bus.done[i] && $urandom_range(3) != 0) bus.req[i] = 1'b0;
                    else if (bus.gnt[i] && $urandom_range(39) == 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    bus.req[i] = 1'b1;
                    set_dur(i, ($urandom_range(9) == 0) ? 15 : int'($urandom_range(4)));
                end
            end
            if ($urandom_range(3) == 0) set_dur(int'($urandom_range(R - 1)), int'($urandom_range(15)));
        end
        reset = 1'b0;
        bus.req = '0;
    endtask

    initial begin
        reset   = 1'b1;
        bus.req = '0;
        bus.dur = '0;
        test_reset();
        test_single_job();
        test_zero_dur();
        test_round_robin();
        test_abort();
        test_reset_mid();
        test_max_dur();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
